// File: rtl/serial_avg_unit.sv
// Serial batch averager: accumulates NSAMP signed samples, then divides the
// sum by the divisor latched with the first sample using a restoring divider.
module serial_avg_unit #(
  parameter int DATAWIDTH = 16,
  parameter int NSAMP     = 8,
  parameter int SUMW      = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATAWIDTH-1:0] in_data,
  input  logic [DATAWIDTH-1:0] num,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATAWIDTH-1:0] avg,
  output logic                 div_by_zero
);

  localparam int CNTW = (NSAMP > 2) ? $clog2(NSAMP) : 1;
  localparam int ITW  = $clog2(SUMW + 1);
  localparam int REMW = DATAWIDTH + 1;

  typedef enum logic [1:0] {ACCUM, DIV, FIX, DONE} state_t;

  state_t                state_q;
  logic [CNTW-1:0]       cnt_q;
  logic [SUMW-1:0]       sum_q;
  logic [DATAWIDTH-1:0]  num_q;
  logic [ITW-1:0]        iter_q;
  logic [REMW-1:0]       rem_q;
  logic [SUMW-1:0]       quo_q;
  logic [DATAWIDTH:0]    dmag_q;
  logic                  in_ready_q;
  logic                  out_valid_q;
  logic [DATAWIDTH-1:0]  avg_q;
  logic                  dbz_q;

  logic [SUMW-1:0]       sum_d;
  logic [DATAWIDTH:0]    num_ext;
  logic [REMW:0]         shifted;
  logic [REMW:0]         trial;
  logic                  num_zero;
  logic                  quo_neg;
  logic [DATAWIDTH-1:0]  avg_d;

  always_comb begin
    sum_d    = sum_q + {{(SUMW-DATAWIDTH){in_data[DATAWIDTH-1]}}, in_data};
    num_ext  = {num_q[DATAWIDTH-1], num_q};
    num_zero = (num_q == '0);
    // Remainder stays below the divisor magnitude, so REMW+1 bits hold the shifted value
    shifted  = {rem_q, quo_q[SUMW-1]};
    trial    = shifted - {1'b0, dmag_q};
    quo_neg  = (sum_q[SUMW-1] ^ num_q[DATAWIDTH-1]) & ~num_zero;
    avg_d    = '0;
    if (!num_zero) begin
      avg_d = quo_neg ? -quo_q[DATAWIDTH-1:0] : quo_q[DATAWIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ACCUM;
      cnt_q       <= '0;
      sum_q       <= '0;
      num_q       <= '0;
      iter_q      <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dmag_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      avg_q       <= '0;
      dbz_q       <= 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (in_valid && in_ready_q) begin
            sum_q <= sum_d;
            if (cnt_q == '0) begin
              num_q <= num;
            end
            if (cnt_q == CNTW'(NSAMP - 1)) begin
              cnt_q      <= '0;
              iter_q     <= '0;
              in_ready_q <= 1'b0;
              state_q    <= DIV;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        DIV: begin
          if (iter_q == '0) begin
            // Setup cycle: load magnitudes; -2^(DATAWIDTH-1) fits thanks to the extra bit
            rem_q  <= '0;
            quo_q  <= sum_q[SUMW-1] ? -sum_q : sum_q;
            dmag_q <= num_q[DATAWIDTH-1] ? -num_ext : num_ext;
            iter_q <= iter_q + 1'b1;
          end else begin
            if (!trial[REMW]) begin
              rem_q <= trial[REMW-1:0];
              quo_q <= {quo_q[SUMW-2:0], 1'b1};
            end else begin
              rem_q <= shifted[REMW-1:0];
              quo_q <= {quo_q[SUMW-2:0], 1'b0};
            end
            if (iter_q == ITW'(SUMW)) begin
              state_q <= FIX;
            end else begin
              iter_q <= iter_q + 1'b1;
            end
          end
        end
        FIX: begin
          avg_q       <= avg_d;
          dbz_q       <= num_zero;
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            sum_q       <= '0;
            cnt_q       <= '0;
            state_q     <= ACCUM;
          end
        end
        default: begin
          state_q <= ACCUM;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign avg         = avg_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_serial_avg_unit.sv
// Scoreboard bench for serial_avg_unit: stimulus pushes hand-computed results,
// a negedge monitor pops and compares them on every output transfer.
module tb_serial_avg_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic [15:0] num = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] avg;
  logic        div_by_zero;

  serial_avg_unit #(.DATAWIDTH(16), .NSAMP(8), .SUMW(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .num         (num),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .avg         (avg),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  int          cycle_cnt = 0;
  int          pass_cnt  = 0;
  int          total_cnt = 0;
  logic [16:0] exp_q[$];
  logic [15:0] smp[8];

  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total_cnt++;
    if (act !== req) $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cycle_cnt);
    else pass_cnt++;
  endtask

  task automatic fail_timeout(input string name);
    total_cnt++;
    $display("FAIL %s: timeout waiting for DUT (cycle %0d)", name, cycle_cnt);
  endtask

  // Monitor: latency, output transfers, and out_valid drop after each transfer
  initial begin
    int  acc_cnt = 0;
    int  last_acc = 0;
    bit  prev_ov = 0;
    bit  expect_low = 0;
    logic [16:0] e;
    forever begin
      @(negedge clk);
      if (rst) begin
        acc_cnt = 0; prev_ov = 0; expect_low = 0;
      end else begin
        if (expect_low) begin
          chk("out_valid_drop", {31'd0, out_valid}, 32'd0);
          chk("in_ready_after_xfer", {31'd0, in_ready}, 32'd1);
          expect_low = 0;
        end
        if (in_valid && in_ready) begin
          acc_cnt++;
          if (acc_cnt == 8) begin
            last_acc = cycle_cnt + 1;
            acc_cnt = 0;
          end
        end
        if (out_valid && !prev_ov)
          chk("latency", cycle_cnt - last_acc, 32'd34);
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            total_cnt++;
            $display("FAIL unexpected_output: got avg=%0h dbz=%0b required none", avg, div_by_zero);
          end else begin
            e = exp_q.pop_front();
            chk("avg", {16'd0, avg}, {16'd0, e[16:1]});
            chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, e[0]});
            $display("xfer avg=%0d (0x%04h) dbz=%0b expected 0x%04h/%0b", $signed(avg), avg, div_by_zero, e[16:1], e[0]);
          end
          expect_low = 1;
        end
        prev_ov = out_valid;
      end
    end
  end

  task automatic send_sample(input logic [15:0] d, input logic [15:0] n);
    int guard = 0;
    in_valid = 1'b1; in_data = d; num = n;
    @(negedge clk);
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) fail_timeout("in_ready");
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    while (exp_q.size() != 0 && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 300) fail_timeout("result");
    @(posedge clk); #1;
  endtask

  task automatic run_batch(input logic [15:0] n_first, input logic [15:0] n_later, input int gap,
                           input logic [15:0] exp_avg, input logic exp_dbz, input bit push, input bit do_drain);
    if (push) exp_q.push_back({exp_avg, exp_dbz});
    for (int i = 0; i < 8; i++) begin
      send_sample(smp[i], (i == 0) ? n_first : n_later);
      if (gap != 0) repeat ((i * 5 + 1) % 4) begin @(posedge clk); #1; end
    end
    if (do_drain) drain();
  endtask

  task automatic fill_const(input logic [15:0] v);
    for (int i = 0; i < 8; i++) smp[i] = v;
  endtask

  task automatic fill_ramp(input logic [15:0] start, input logic [15:0] step);
    for (int i = 0; i < 8; i++) smp[i] = start + step * 16'(i);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_avg", {16'd0, avg}, 32'd0);
    chk("rst_dbz", {31'd0, div_by_zero}, 32'd0);
    @(posedge clk); #1;

    fill_ramp(16'd1, 16'd1);
    run_batch(16'd4, 16'd4, 0, 16'd9, 1'b0, 1, 1);          // 36/4
    fill_const(16'hFFF6);
    run_batch(16'd3, 16'd3, 0, 16'hFFE6, 1'b0, 1, 1);       // -80/3 = -26
    run_batch(16'hFFFD, 16'hFFFD, 0, 16'd26, 1'b0, 1, 1);   // -80/-3 = 26
    fill_const(16'd5);
    run_batch(16'd0, 16'd0, 0, 16'd0, 1'b1, 1, 1);          // divide by zero
    run_batch(16'd2, 16'd2, 0, 16'd20, 1'b0, 1, 1);         // 40/2
    fill_const(16'h7FFF);
    run_batch(16'd1, 16'd1, 0, 16'hFFF8, 1'b0, 1, 1);       // 262136 wraps
    run_batch(16'h8000, 16'h8000, 0, 16'hFFF9, 1'b0, 1, 1); // 262136/-32768 = -7

    // Hold in DONE with out_ready low while offering samples
    fill_ramp(16'd1, 16'd1);
    out_ready = 1'b0;
    run_batch(16'd4, 16'd4, 0, 16'd9, 1'b0, 1, 0);
    guard = 0;
    while (!out_valid && guard < 100) begin @(posedge clk); #1; guard++; end
    if (guard >= 100) fail_timeout("hold_out_valid");
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_data = 16'd99;
      @(negedge clk);
      chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
      chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_avg", {16'd0, avg}, 32'd9);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain();

    // Gaps and a num change after the first accept: 3600/7 = 514
    fill_ramp(16'd100, 16'd100);
    run_batch(16'd7, 16'd2, 1, 16'd514, 1'b0, 1, 1);

    // Reset during the 10th DIV cycle discards the batch
    fill_const(16'd1000);
    run_batch(16'd1, 16'd1, 0, 16'd0, 1'b0, 0, 0);
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_avg", {16'd0, avg}, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    fill_ramp(16'd1, 16'd1);
    run_batch(16'd4, 16'd4, 0, 16'd9, 1'b0, 1, 1);

    repeat (50) @(posedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/serial_avg_unit.md
Name: serial_avg_unit

Overview:
- Time-multiplexed counterpart of the pipelined parallel averager datapath.
- Accepts one signed sample per handshake and accumulates a batch of NSAMP samples.
- Divides the batch sum by a divisor latched at batch start, using an iterative restoring divider.
- Presents the signed result on a valid/ready output port; used where the sample operands arrive serially, not in parallel.

Parameters:
- DATAWIDTH, 16: width of samples, divisor and result (signed two's complement).
- NSAMP, 8: samples per batch; legal range 2..256.
- SUMW, 32: accumulator and dividend width; must be at least DATAWIDTH + clog2(NSAMP).

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  sample present on in_data.
- in_ready  output  1  block can accept a sample this cycle.
- in_data  input  DATAWIDTH  signed sample.
- num  input  DATAWIDTH  signed divisor; sampled only on the first accepted sample of a batch.
- out_valid  output  1  avg and div_by_zero are valid.
- out_ready  input  1  consumer takes the result.
- avg  output  DATAWIDTH  signed quotient, sum/num truncated toward zero, low DATAWIDTH bits.
- div_by_zero  output  1  latched divisor was 0.

Behaviour:
- Reset (rst=1 at a clock edge) forces:
  - state=ACCUM, sample count=0, sum=0, latched divisor=0.
  - in_ready=1 from the first cycle after reset.
  - out_valid=0, avg=0, div_by_zero=0.
- Reset in any state, including mid-DIV or DONE, discards the batch and pending result; no output is produced for it.
- Transfer rules: an input transfer occurs when in_valid & in_ready; an output transfer occurs when out_valid & out_ready.
- All outputs are registered.
- ACCUM state:
  - in_ready=1.
  - Each accepted sample is sign-extended to SUMW and added to sum; the SUMW add wraps, no saturation.
  - The first accepted sample of a batch also latches num.
  - in_valid gaps are allowed; count increments only on accept.
  - On the NSAMP-th accept: the final sum is registered and state goes to DIV next cycle.
- DIV state:
  - in_ready=0.
  - Dividend magnitude is |sum| in SUMW bits; divisor magnitude is |num| in DATAWIDTH+1 bits, so -32768 is handled.
  - Runs exactly SUMW restoring iterations, one per cycle, then goes to FIX.
  - A zero divisor runs the same iterations (timing is uniform); the quotient is forced to 0.
- FIX state (1 cycle):
  - Quotient is negated if sign(sum) XOR sign(num) and the divisor is nonzero.
  - avg register <= low DATAWIDTH bits of the quotient (two's-complement wrap).
  - div_by_zero <= (divisor==0).
  - State goes to DONE.
- DONE state:
  - out_valid=1; avg and div_by_zero held stable while out_ready=0.
  - in_ready=0; samples offered are not consumed.
  - On out_ready=1: out_valid drops next cycle; state goes to ACCUM with count=0 and sum=0; in_ready=1 that next cycle.
- Latency: last sample accepted at edge T -> out_valid high after edge T+SUMW+2 (T+34 at defaults).
- Throughput at defaults: NSAMP accept cycles + SUMW+2 + 1 per batch minimum.
- Changes on num after the first accept of a batch have no effect on that batch.
- avg and div_by_zero keep their last values after the output transfer until the next FIX; only out_valid qualifies them.
- Remainder is discarded.

Test Plan:
- Samples 1..8, num=4, out_ready=1 -> avg=9 (sum 36), div_by_zero=0, out_valid exactly 34 cycles after the 8th accept, high for 1 cycle.
- Eight samples of -10, num=3 -> sum -80, avg=-26 (truncation toward zero); second run with num=-3 -> avg=26.
- Samples 5 x8, num=0 -> avg=0, div_by_zero=1, same 34-cycle latency; the following batch with num=2 gives div_by_zero=0.
- Eight samples of 32767, num=1 -> sum 262136 (0x3FFF8), avg=0xFFF8 (-8); with num=-32768 -> avg=-7 (0xFFF9).
- Hold out_ready=0 for 10 cycles in DONE while driving in_valid=1 -> avg stable, in_ready=0, no sample consumed. Random in_valid gaps plus a num change mid-batch -> result uses the first-latched num.
- Assert rst for 1 cycle during DIV (cycle 10) -> next cycle out_valid=0, avg=0, in_ready=1; a subsequent batch (1..8, num=4) still yields avg=9.
